// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned multiply/divide unit for the EX stage.
// Shift-add multiplier and restoring divider, one bit per cycle, with a
// pipeline stall held until the result is ready.
// Optional build macro: MULDIV_EARLY_OUT_EN lets zero operands and divide
// by zero skip the iterative phase and finish in a single cycle.
module muldiv_sequencer #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            stall_ex,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [2:0] F3_MULHU = 3'b011;
   localparam logic [2:0] F3_DIVU  = 3'b101;
   localparam logic [2:0] F3_REMU  = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     counter;
   logic [2:0]        op_q;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mcand;
   logic [XLEN:0]     rem;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   dvsr;

   logic              start_ok;
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] prod_step;
   logic [XLEN+1:0]   div_shift;
   logic [XLEN+1:0]   div_diff;
   logic [XLEN:0]     rem_step;
   logic [XLEN-1:0]   quot_step;
   logic [XLEN-1:0]   final_val;

   assign start_ok = start && !flush;

`ifdef MULDIV_EARLY_OUT_EN
   logic            early_hit;
   logic [XLEN-1:0] early_val;

   // Zero operands and divide by zero have a known answer, so they bypass BUSY
   always_comb begin
      early_hit = (op_a == '0) || (op_b == '0);
      early_val = '0;
      if (op_b == '0) begin
         if (funct3 == F3_DIVU) begin
            early_val = '1;
         end else if (funct3 == F3_REMU) begin
            early_val = op_a;
         end
      end
   end
`endif

   // One iteration of both datapaths: shift-add multiply and restoring divide
   always_comb begin
      add_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_step = {add_sum, prod[XLEN-1:1]};
      div_shift = {rem, quot[XLEN-1]};
      div_diff  = div_shift - {2'b00, dvsr};
      if (!div_diff[XLEN+1]) begin
         rem_step  = div_diff[XLEN:0];
         quot_step = {quot[XLEN-2:0], 1'b1};
      end else begin
         rem_step  = div_shift[XLEN:0];
         quot_step = {quot[XLEN-2:0], 1'b0};
      end
      case (op_q)
         F3_MULHU: final_val = prod_step[2*XLEN-1:XLEN];
         F3_DIVU:  final_val = quot_step;
         F3_REMU:  final_val = rem_step[XLEN-1:0];
         default:  final_val = prod_step[XLEN-1:0];
      endcase
   end

   // Next-state and stall decode; stall drops in DONE so EX/MEM captures result
   always_comb begin
      state_nxt = state;
      stall_ex  = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               stall_ex  = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
               state_nxt = early_hit ? DONE : BUSY;
`else
               state_nxt = BUSY;
`endif
            end
         end
         BUSY: begin
            stall_ex = 1'b1;
            if (flush) begin
               state_nxt = IDLE;
            end else if (counter == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign done = (state == DONE);

   // State, operand latching, per-cycle iteration and result capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         counter <= '0;
         op_q    <= '0;
         prod    <= '0;
         mcand   <= '0;
         rem     <= '0;
         quot    <= '0;
         dvsr    <= '0;
         result  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  counter <= CW'(XLEN);
                  op_q    <= funct3;
                  prod    <= {{XLEN{1'b0}}, op_b};
                  mcand   <= op_a;
                  rem     <= '0;
                  quot    <= op_a;
                  dvsr    <= op_b;
`ifdef MULDIV_EARLY_OUT_EN
                  if (early_hit) begin
                     counter <= '0;
                     result  <= early_val;
                  end
`endif
               end
            end
            BUSY: begin
               if (!flush) begin
                  counter <= counter - CW'(1);
                  prod    <= prod_step;
                  rem     <= rem_step;
                  quot    <= quot_step;
                  if (counter == CW'(1)) begin
                     result <= final_val;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed table-driven bench for muldiv_sequencer,
// plus hand-written flush, reset and back-to-back sequences.
module tb_muldiv_sequencer;

   localparam int XLEN = 64;
   localparam int LAT  = XLEN + 1;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int LZ = 1;
`else
   localparam int LZ = XLEN + 1;
`endif

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   logic            clk;
   logic            reset;
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            stall_ex;
   logic            done;
   logic [XLEN-1:0] result;

   int nvec;
   int nfail;
   int done_count;

   vec_t vecs[11];

   muldiv_sequencer #(.XLEN(XLEN)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .funct3(funct3),
      .op_a(op_a),
      .op_b(op_b),
      .flush(flush),
      .stall_ex(stall_ex),
      .done(done),
      .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every done pulse, sampled away from the active edge
   always @(negedge clk) begin
      if (done === 1'b1) done_count <= done_count + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nvec++;
      if (actual !== expected) begin
         nfail++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Runs one op from a posedge+1 IDLE point; returns at posedge+1 in IDLE
   task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] exp, input int lat);
      int cyc;
      int stalls;
      bit seen;
      start  = 1'b1;
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      cyc    = 0;
      stalls = 0;
      seen   = 0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         if (stall_ex) stalls++;
         if (done) begin
            seen = 1;
         end else begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 3) begin
               op_a = ~a;
               op_b = b ^ 64'h5555;
            end
         end
      end
      checkOutput({name, "/done_seen"}, 64'(seen), 64'd1);
      checkOutput({name, "/latency"}, 64'(cyc), 64'(lat));
      checkOutput({name, "/stall_cycles"}, 64'(stalls), 64'(lat));
      checkOutput({name, "/result"}, result, exp);
      checkOutput({name, "/stall_in_done"}, 64'(stall_ex), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput({name, "/done_one_cycle"}, 64'(done), 64'd0);
      checkOutput({name, "/result_held"}, result, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt_before;
      int cyc;
      logic [63:0] prev_result;

      nvec       = 0;
      nfail      = 0;
      done_count = 0;
      reset      = 1'b1;
      start      = 1'b0;
      flush      = 1'b0;
      funct3     = 3'b000;
      op_a       = '0;
      op_b       = '0;

      vecs[0]  = '{"MUL_7x6",      3'b000, 64'd7,                  64'd6,  64'd42,                 LAT};
      vecs[1]  = '{"MULHU_ones_x2",3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,  64'd1,                  LAT};
      vecs[2]  = '{"MUL_ones_x2",  3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,  64'hFFFF_FFFF_FFFF_FFFE, LAT};
      vecs[3]  = '{"DIVU_100_7",   3'b101, 64'd100,                64'd7,  64'd14,                 LAT};
      vecs[4]  = '{"REMU_100_7",   3'b111, 64'd100,                64'd7,  64'd2,                  LAT};
      vecs[5]  = '{"DIVU_5_0",     3'b101, 64'd5,                  64'd0,  64'hFFFF_FFFF_FFFF_FFFF, LZ};
      vecs[6]  = '{"REMU_5_0",     3'b111, 64'd5,                  64'd0,  64'd5,                  LZ};
      vecs[7]  = '{"F3_001_as_MUL",3'b001, 64'h0000_0001_0000_0001, 64'd3,  64'h0000_0003_0000_0003, LAT};
      vecs[8]  = '{"MULHU_2p63_x4",3'b011, 64'h8000_0000_0000_0000, 64'd4,  64'd2,                  LAT};
      vecs[9]  = '{"DIVU_ones_16", 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, LAT};
      vecs[10] = '{"REMU_ones_16", 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF,                  LAT};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset/done", 64'(done), 64'd0);
      checkOutput("reset/stall_ex", 64'(stall_ex), 64'd0);
      checkOutput("reset/result", result, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Table of directed vectors
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end
      prev_result = vecs[10].exp;

      // Flush at BUSY cycle 10, then held one cycle in IDLE
      cnt_before = done_count;
      start  = 1'b1;
      funct3 = 3'b000;
      op_a   = 64'd9;
      op_b   = 64'd9;
      for (cyc = 0; cyc < 10; cyc++) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flush/stall_busy", 64'(stall_ex), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("flush/stall_idle", 64'(stall_ex), 64'd0);
      checkOutput("flush/done_idle", 64'(done), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      repeat (70) @(posedge clk);
      #1;
      checkOutput("flush/no_done", 64'(done_count - cnt_before), 64'd0);
      checkOutput("flush/result_kept", result, prev_result);

      // Reset at BUSY cycle 30 of a fresh op
      start  = 1'b1;
      funct3 = 3'b000;
      op_a   = 64'd3;
      op_b   = 64'd5;
      for (cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("midreset/stall_ex", 64'(stall_ex), 64'd0);
      checkOutput("midreset/done", 64'(done), 64'd0);
      checkOutput("midreset/result", result, 64'd0);
      cnt_before = done_count;
      repeat (70) @(posedge clk);
      #1;
      checkOutput("midreset/no_done", 64'(done_count - cnt_before), 64'd0);
      applyStimulus("after_reset_MUL", 3'b000, 64'd11, 64'd13, 64'd143, LAT);

      // Back-to-back ops with start dropped one cycle between them
      cnt_before = done_count;
      applyStimulus("b2b_first", 3'b101, 64'd1000, 64'd10, 64'd100, LAT);
      applyStimulus("b2b_second", 3'b000, 64'd3, 64'd4, 64'd12, LAT);
      checkOutput("b2b/done_pulses", 64'(done_count - cnt_before), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle unsigned multiply/divide unit plus its controller, next to the single-cycle ALU in the execute stage of the 5-stage pipeline.
- Accepts a level-held M-type request from the EX stage, operands already forwarded, funct3 from the instruction.
- Holds the pipeline with a stall until the result is ready, then presents the result for one cycle for capture into EX/MEM.
- Shift-add multiplier and restoring divider, one bit per cycle.

Parameters:
XLEN, 64, operand/result width; the iteration counter is $clog2(XLEN)+1 bits wide.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  EX holds a valid M-type op; held high until the instruction leaves EX
funct3  input  3  000 MUL (low XLEN bits), 011 MULHU (high XLEN bits), 101 DIVU, 111 REMU; other codes are treated as MUL
op_a  input  XLEN  forwarded rs1 value (multiplicand/dividend)
op_b  input  XLEN  forwarded rs2 value (multiplier/divisor)
flush  input  1  squash the EX instruction (branch mispredict)
stall_ex  output  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM
done  output  1  one-cycle pulse, result valid
result  output  XLEN  selected product half, quotient or remainder

Behaviour:
- Clock is clk; reset is synchronous and active-high on reset. Reset wins over every other input.
- Reset values: state=IDLE, counter=0, product/remainder/quotient regs=0, result=0, done=0, stall_ex=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY when start && !flush. On that edge:
  - latch op_a and op_b into working regs;
  - latch funct3 into op_q;
  - counter=XLEN;
  - clear the accumulator (MUL) or the partial remainder (DIV).
- BUSY: one iteration per cycle, counter decrements; BUSY -> DONE on the edge where counter goes 1->0.
- DONE -> IDLE unconditionally. start is ignored in DONE because the same instruction still holds it.
- stall_ex = (IDLE && start && !flush) || BUSY. It is combinational and deasserted in DONE so the pipeline advances and captures result.
- done = (state==DONE), registered-state decode.
- result is updated on entry to DONE and holds its value until the next entry to DONE.
- Latency: request seen at cycle 0, BUSY cycles 1..XLEN, done at cycle XLEN+1. stall_ex is high for exactly XLEN+1 cycles.
- Multiplier: 2*XLEN product register, unsigned shift-add over multiplier bits LSB-first.
  - MUL returns product[XLEN-1:0]; MULHU returns product[2XLEN-1:XLEN].
- Divider: restoring, XLEN+1-bit partial remainder, quotient shifted in MSB-first.
- Divide by zero follows RISC-V with no trap: DIVU returns all-ones; REMU returns op_a. This falls out of the restoring algorithm and must not be special-cased unless the optional feature is enabled.
- flush in IDLE: no transition, stall_ex=0.
- flush in BUSY: next state is IDLE, done is never pulsed, result is unchanged.
- flush in DONE: DONE->IDLE as normal, done still pulses (the consumer gates it).
- Operands changing on op_a/op_b during BUSY have no effect, because the working regs were latched at start.
- reset mid-operation: IDLE on the next edge with all regs cleared; the next start begins a fresh operation.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - a DIVU/REMU with op_b==0, or any op with op_a==0 or op_b==0, skips BUSY (IDLE -> DONE directly) with the spec-correct result (0 for MUL/MULHU with a zero operand; the divide-by-zero values for DIVU/REMU);
  - done at cycle 1 and stall_ex high for exactly 1 cycle;
  - a DIVU/REMU with op_a==0 and op_b!=0 also takes the early path with result 0.
- Undefined: every operation takes the full XLEN+1 cycles.

Test Plan:
- MUL: start=1, funct3=000, op_a=7, op_b=6 -> stall_ex high for 65 cycles, done at cycle 65, result=42.
- MULHU: op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 -> result=1. Same operands with MUL -> result=0xFFFF_FFFF_FFFF_FFFE.
- DIVU/REMU: op_a=100, op_b=7 -> DIVU result=14, REMU result=2, each done at cycle 65.
- Divide by zero: DIVU op_a=5, op_b=0 -> result=0xFFFF_FFFF_FFFF_FFFF; REMU -> result=5. With MULDIV_EARLY_OUT_EN defined, done at cycle 1 instead.
- Flush/reset mid-op: flush asserted at BUSY cycle 10 -> stall_ex=0 and IDLE next cycle, no done, result unchanged. Then reset asserted at BUSY cycle 30 of a new op -> all outputs 0 on the next edge.
- Back-to-back: start held through DONE, then dropped for 1 cycle, then raised again with op_a=3, op_b=4 (MUL) -> exactly one done per op, second result=12.
